core_launcher: RTL and testbench
================================

# core_launcher

Host-side initiator for the processor's `req`/`done` handshake; it is the other end of the core's run protocol. It preloads data memory from a host stream while holding the core in reset, then releases the core and raises `core_req`. It waits for `core_done` or a cycle timeout, then streams a window of data memory back to the host. It sits between the host/testbench stream ports and the core plus data-memory write/read port.

## Interface
- `AW`, 8, data-memory address width
- `DW`, 8, data-memory word width
- `CW`, 16, run-cycle counter and timeout width

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a run; sampled only in IDLE
- `dump_base`  in  AW  first dump address; sampled with `start`
- `dump_len`  in  AW+1  number of words to dump (0..2**AW); sampled with `start`
- `timeout_max`  in  CW  maximum RUN cycles; 0 disables the timeout; sampled with `start`
- `ld_valid`, `ld_last`  in  1  preload beat valid, and last beat
- `ld_addr`  in  AW  preload address
- `ld_data`  in  DW  preload data
- `ld_ready`  out  1  preload beat accepted
- `mem_wr_en`  out  1  data-memory write strobe
- `mem_rd_en`  out  1  data-memory read strobe
- `mem_addr`  out  AW  data-memory address
- `mem_wdata`  out  DW  write data
- `mem_rdata`  in  DW  read data, valid the cycle after `mem_rd_en`
- `core_rst`  out  1  active-high reset to the core
- `core_req`  out  1  run request to the core
- `core_done`  in  1  core finished (level)
- `res_valid`  out  1  dump word valid
- `res_data`  out  DW  dump word
- `res_ready`  in  1  host accepts dump word
- `busy`  out  1  not in IDLE
- `run_done`  out  1  one-cycle pulse at end of sequence
- `status`  out  2  00 none, 01 OK, 10 TIMEOUT
- `cycles`  out  CW  RUN-cycle count of the last run

## Operation
- States: IDLE, LOAD, LAUNCH, RUN, DUMP_RD, DUMP_OUT, FINISH.
- **IDLE:** `start`=1 latches `dump_base`, `dump_len` and `timeout_max`, clears `cycles`, sets `status`=00, and moves to LOAD.
- **LOAD:**
  - `ld_ready`=1.
  - Each accepted beat (`ld_valid`&`ld_ready`) drives `mem_wr_en`=1, `mem_addr`=`ld_addr` and `mem_wdata`=`ld_data` in the same cycle.
  - An accepted beat with `ld_last`=1 moves to LAUNCH.
  - An empty preload is not allowed: at least one beat is required.
- **LAUNCH:** one cycle; `core_rst`=0. Then moves to RUN.
- **RUN:**
  - `core_rst`=0, `core_req`=1.
  - Each cycle in which `core_done`=0, `cycles` increments, saturating at 2**CW-1.
  - `core_done`=1 sets `status`=OK. The state then moves to DUMP_RD, or to FINISH if `dump_len`=0.
  - If `timeout_max`≠0 and `cycles`==`timeout_max` with `core_done`=0, then `status`=TIMEOUT and the state moves to FINISH. No dump is performed.
  - `core_done` and timeout in the same cycle: `core_done` wins.
- **DUMP_RD:** `mem_rd_en`=1, `mem_addr`=`dump_base`+`idx` (wraps modulo 2**AW). Moves to DUMP_OUT.
- **DUMP_OUT:**
  - On entry, `res_data` is registered from `mem_rdata`.
  - `res_valid`=1 is held, with `res_data` stable, until `res_ready`=1.
  - On acceptance, `idx` increments. If `idx`+1==`dump_len` the state moves to FINISH, otherwise to DUMP_RD.
- **FINISH:** `run_done`=1 for one cycle, then the state moves to IDLE.
- `core_rst`=1 in every state except LAUNCH and RUN.
- `mem_*` strobes are 0 outside LOAD and DUMP_RD.

## Timing
- Reset values: state IDLE, `core_rst`=1, and every other output 0 (`cycles`=0, `status`=00).
- Reset is asynchronous; asserting it mid-operation aborts to IDLE with reset values. Memory contents are not touched.
- Preload accepts one beat per cycle.
- `core_req` rises 2 cycles after the `ld_last` beat is accepted.
- Dump read latency is 1 cycle. Peak dump throughput is one word per 2 cycles.
- `status` and `cycles` hold until the next `start`.
- `start` asserted while `busy` is ignored.

## Structure
- `launcher_pkg`:
  - `state_t` enum, 7 states.
  - `status_t` encodings: ST_NONE=2'b00, ST_OK=2'b01, ST_TIMEOUT=2'b10.
- Single module. No sub-module is needed; the FSM, index counter and cycle counter are inline.

## Test plan
- **Preload and normal run:** preload 3 beats (addr 0..2 = 8'h11, 8'h22, 8'h33, last on the third). Core asserts `done` after 5 RUN cycles; `dump_base`=0, `dump_len`=3. Required: `status`=01, `cycles`=5, `res_data` sequence 11, 22, 33, and one `run_done` pulse.
- **Timeout:** `timeout_max`=4, `core_done` held at 0. Required: `status`=10, `cycles`=4, no `res_valid`, FINISH reached 4 cycles after RUN entry.
- **Zero-length dump:** `dump_len`=0, `done` on the first RUN cycle. Required: `cycles`=0, `status`=01, no `mem_rd_en`, `run_done` 2 cycles after RUN entry.
- **Dump address wrap and backpressure:**
  - Stimulus: `dump_base`=8'hFE, `dump_len`=3, `res_ready` low for 3 cycles per word.
  - Required: addresses FE, FF, 00; `res_data` stable while stalled; each word is transferred exactly once.
- **Reset mid-dump:** assert `reset` during DUMP_OUT. Required: `res_valid`=0 and `core_rst`=1 immediately; a later `start` runs cleanly.
- **Start while busy:** pulse `start` during RUN. Required: ignored, and `dump_base`, `dump_len` and `timeout_max` keep their latched values.

Source files
------------

// File: rtl/launcher_pkg.sv
// Shared types for the core launcher: FSM state and run status encodings.
package launcher_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_OUT,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_OK      = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_t;

endpackage

// File: rtl/core_launcher.sv
// Host-side run initiator: preloads data memory, launches the core via req/done,
// then streams a window of data memory back to the host.
module core_launcher
  import launcher_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] dump_base,
  input  logic [AW:0]   dump_len,
  input  logic [CW-1:0] timeout_max,
  input  logic          ld_valid,
  input  logic          ld_last,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_rst,
  output logic          core_req,
  input  logic          core_done,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  input  logic          res_ready,
  output logic          busy,
  output logic          run_done,
  output logic [1:0]    status,
  output logic [CW-1:0] cycles
);

  state_t        state, state_nxt;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic [AW:0]   idx_q;
  logic [CW-1:0] tmax_q;
  logic [DW-1:0] data_q;
  logic          out_first;
  logic [CW-1:0] cyc_inc;
  logic          timeout_hit;
  logic          last_word;

  // Saturating run counter; timeout fires when the count of this cycle reaches the limit.
  always_comb begin
    cyc_inc     = (cycles == {CW{1'b1}}) ? cycles : cycles + 1'b1;
    timeout_hit = (tmax_q != '0) && (cyc_inc == tmax_q);
    last_word   = ((AW+1)'(idx_q + 1'b1) == len_q);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_LOAD;
      S_LOAD:     if (ld_valid && ld_last) state_nxt = S_LAUNCH;
      S_LAUNCH:   state_nxt = S_RUN;
      S_RUN: begin
        if (core_done)        state_nxt = (len_q == '0) ? S_FINISH : S_DUMP_RD;
        else if (timeout_hit) state_nxt = S_FINISH;
      end
      S_DUMP_RD:  state_nxt = S_DUMP_OUT;
      S_DUMP_OUT: if (res_ready) state_nxt = last_word ? S_FINISH : S_DUMP_RD;
      S_FINISH:   state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State, registered strobes and run bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ld_ready  <= 1'b0;
      core_rst  <= 1'b1;
      core_req  <= 1'b0;
      mem_rd_en <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      run_done  <= 1'b0;
      status    <= ST_NONE;
      cycles    <= '0;
      base_q    <= '0;
      len_q     <= '0;
      tmax_q    <= '0;
      idx_q     <= '0;
      out_first <= 1'b0;
      data_q    <= '0;
    end else begin
      state     <= state_nxt;
      ld_ready  <= (state_nxt == S_LOAD);
      core_rst  <= !((state_nxt == S_LAUNCH) || (state_nxt == S_RUN));
      core_req  <= (state_nxt == S_RUN);
      mem_rd_en <= (state_nxt == S_DUMP_RD);
      res_valid <= (state_nxt == S_DUMP_OUT);
      busy      <= (state_nxt != S_IDLE);
      run_done  <= (state == S_FINISH);
      out_first <= (state_nxt == S_DUMP_OUT) && (state != S_DUMP_OUT);
      if (out_first) data_q <= mem_rdata;
      case (state)
        S_IDLE: if (start) begin
          base_q <= dump_base;
          len_q  <= dump_len;
          tmax_q <= timeout_max;
          idx_q  <= '0;
          cycles <= '0;
          status <= ST_NONE;
        end
        S_RUN: begin
          if (core_done) begin
            status <= ST_OK;
          end else begin
            cycles <= cyc_inc;
            if (timeout_hit) status <= ST_TIMEOUT;
          end
        end
        S_DUMP_OUT: if (res_ready) idx_q <= (AW+1)'(idx_q + 1'b1);
        default: ;
      endcase
    end
  end

  // Read data arrives in the first DUMP_OUT cycle and is held from then on.
  assign res_data  = out_first ? mem_rdata : data_q;
  assign mem_wr_en = ld_ready && ld_valid;
  assign mem_addr  = ld_ready ? ld_addr : AW'(base_q + idx_q[AW-1:0]);
  assign mem_wdata = ld_ready ? ld_data : '0;

endmodule

// File: tb/tb_core_launcher.sv
// Directed self-checking bench for core_launcher with a behavioural data memory.
module tb_core_launcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  dump_base;
  logic [8:0]  dump_len;
  logic [15:0] timeout_max;
  logic        ld_valid, ld_last, ld_ready;
  logic [7:0]  ld_addr, ld_data;
  logic        mem_wr_en, mem_rd_en;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        core_rst, core_req, core_done;
  logic        res_valid, res_ready;
  logic [7:0]  res_data;
  logic        busy, run_done;
  logic [1:0]  status;
  logic [15:0] cycles;

  int n_tests = 0;
  int n_fail  = 0;

  core_launcher #(.AW(8), .DW(8), .CW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .dump_base(dump_base),
    .dump_len(dump_len), .timeout_max(timeout_max), .ld_valid(ld_valid),
    .ld_last(ld_last), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .core_rst(core_rst),
    .core_req(core_req), .core_done(core_done), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready), .busy(busy), .run_done(run_done),
    .status(status), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Synchronous data memory, one-cycle read latency.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Observers sampled on the falling edge.
  logic [7:0] res_q[$];
  logic [7:0] rd_q[$];
  int         n_done, n_resv, stable_err;
  logic       prev_stall;
  logic [7:0] prev_data;
  always @(negedge clk) begin
    if (res_valid && res_ready) res_q.push_back(res_data);
    if (mem_rd_en) rd_q.push_back(mem_addr);
    if (run_done) n_done++;
    if (res_valid) n_resv++;
    if (prev_stall && (!res_valid || res_data != prev_data)) stable_err++;
    prev_stall = res_valid && !res_ready;
    prev_data  = res_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    check({tag, "_n"}, 32'(got.size()), 32'(exp.size()));
    foreach (exp[i])
      if (i < got.size()) check($sformatf("%s_%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic clear_mon();
    res_q.delete();
    rd_q.delete();
    n_done = 0;
    n_resv = 0;
    stable_err = 0;
  endtask

  task automatic kick(input logic [7:0] b, input logic [8:0] l, input logic [15:0] t);
    @(posedge clk); #1;
    start = 1'b1; dump_base = b; dump_len = l; timeout_max = t;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input string tag, input logic [7:0] a, input logic [7:0] d,
                           input logic last);
    int n = 0;
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    @(negedge clk);
    while (!ld_ready && n < 50) begin @(negedge clk); n++; end
    check(tag, 32'(ld_ready), 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    @(negedge clk);
    while (!core_req && n < 100) begin @(negedge clk); n++; end
    check(tag, 32'(core_req), 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!run_done && n < 200);
  endtask

  task automatic wait_resv(input string tag);
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    check(tag, 32'(res_valid), 32'd1);
  endtask

  logic [7:0] exp_q[$];
  int         cnt;

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    reset = 1'b0; start = 1'b0; dump_base = '0; dump_len = '0; timeout_max = '0;
    ld_valid = 1'b0; ld_last = 1'b0; ld_addr = '0; ld_data = '0;
    core_done = 1'b0; res_ready = 1'b0;
    clear_mon();
    prev_stall = 1'b0; prev_data = '0;

    // Reset values
    #12;
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_core_req", 32'(core_req), 32'd0);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_status",   32'(status), 32'd0);
    check("rst_cycles",   32'(cycles), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    @(posedge clk); #1; reset = 1'b1;

    // Preload and normal run
    clear_mon();
    res_ready = 1'b1;
    kick(8'h00, 9'd3, 16'd0);
    send_beat("t1_b0", 8'h00, 8'h11, 1'b0);
    send_beat("t1_b1", 8'h01, 8'h22, 1'b0);
    send_beat("t1_b2", 8'h02, 8'h33, 1'b1);
    @(negedge clk);
    check("t1_launch_req", 32'(core_req), 32'd0);
    check("t1_launch_rst", 32'(core_rst), 32'd0);
    @(negedge clk);
    check("t1_req_rise", 32'(core_req), 32'd1);
    repeat (5) @(posedge clk);
    #1 core_done = 1'b1;
    wait_done(cnt);
    check("t1_run_done", 32'(run_done), 32'd1);
    repeat (3) @(negedge clk);
    core_done = 1'b0;
    check("t1_status", 32'(status), 32'd1);
    check("t1_cycles", 32'(cycles), 32'd5);
    check("t1_done_pulses", 32'(n_done), 32'd1);
    exp_q = {8'h11, 8'h22, 8'h33};
    check_q("t1_res", res_q, exp_q);
    exp_q = {8'h00, 8'h01, 8'h02};
    check_q("t1_rdaddr", rd_q, exp_q);

    // Timeout
    clear_mon();
    kick(8'h00, 9'd3, 16'd4);
    send_beat("t2_b0", 8'h05, 8'h55, 1'b1);
    wait_req("t2_req");
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (core_req && cnt < 50);
    check("t2_finish_lat", 32'(cnt), 32'd4);
    wait_done(cnt);
    repeat (2) @(negedge clk);
    check("t2_status", 32'(status), 32'd2);
    check("t2_cycles", 32'(cycles), 32'd4);
    check("t2_no_resv", 32'(n_resv), 32'd0);
    check("t2_no_rd", 32'(rd_q.size()), 32'd0);
    check("t2_done_pulses", 32'(n_done), 32'd1);

    // Zero-length dump
    clear_mon();
    kick(8'h00, 9'd0, 16'd0);
    send_beat("t3_b0", 8'h06, 8'h66, 1'b1);
    wait_req("t3_req");
    core_done = 1'b1;
    wait_done(cnt);
    check("t3_done_lat", 32'(cnt), 32'd2);
    repeat (2) @(negedge clk);
    core_done = 1'b0;
    check("t3_status", 32'(status), 32'd1);
    check("t3_cycles", 32'(cycles), 32'd0);
    check("t3_no_rd", 32'(rd_q.size()), 32'd0);

    // Dump address wrap with backpressure
    clear_mon();
    res_ready = 1'b0;
    kick(8'hFE, 9'd3, 16'd0);
    send_beat("t4_b0", 8'hFE, 8'hA1, 1'b0);
    send_beat("t4_b1", 8'hFF, 8'hB2, 1'b0);
    send_beat("t4_b2", 8'h00, 8'hC3, 1'b1);
    wait_req("t4_req");
    core_done = 1'b1;
    for (int w = 0; w < 3; w++) begin
      wait_resv($sformatf("t4_resv_%0d", w));
      repeat (3) begin @(posedge clk); #1; end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
    end
    wait_done(cnt);
    repeat (2) @(negedge clk);
    core_done = 1'b0;
    exp_q = {8'hFE, 8'hFF, 8'h00};
    check_q("t4_rdaddr", rd_q, exp_q);
    exp_q = {8'hA1, 8'hB2, 8'hC3};
    check_q("t4_res", res_q, exp_q);
    check("t4_stable", 32'(stable_err), 32'd0);
    check("t4_status", 32'(status), 32'd1);

    // Reset mid-dump, then a clean run
    clear_mon();
    kick(8'h00, 9'd3, 16'd0);
    send_beat("t5_b0", 8'h10, 8'h77, 1'b1);
    wait_req("t5_req");
    core_done = 1'b1;
    wait_resv("t5_resv");
    #2 reset = 1'b0;
    #1;
    check("t5_rst_resv", 32'(res_valid), 32'd0);
    check("t5_rst_core_rst", 32'(core_rst), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    core_done = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1 reset = 1'b1;
    clear_mon();
    kick(8'h00, 9'd2, 16'd0);
    send_beat("t5_b1", 8'h01, 8'h5A, 1'b1);
    wait_req("t5_req2");
    core_done = 1'b1;
    wait_done(cnt);
    repeat (2) @(negedge clk);
    core_done = 1'b0;
    exp_q = {8'hC3, 8'h5A};
    check_q("t5_res", res_q, exp_q);
    check("t5_status", 32'(status), 32'd1);

    // Start while busy is ignored
    clear_mon();
    kick(8'h10, 9'd1, 16'd0);
    send_beat("t6_b0", 8'h10, 8'h99, 1'b1);
    wait_req("t6_req");
    @(posedge clk); #1;
    start = 1'b1; dump_base = 8'h00; dump_len = 9'd2; timeout_max = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 core_done = 1'b1;
    wait_done(cnt);
    repeat (2) @(negedge clk);
    core_done = 1'b0;
    check("t6_status", 32'(status), 32'd1);
    check("t6_cycles", 32'(cycles), 32'd5);
    exp_q = {8'h10};
    check_q("t6_rdaddr", rd_q, exp_q);
    exp_q = {8'h99};
    check_q("t6_res", res_q, exp_q);
    check("t6_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
